fft_bitrev_reorder: RTL

- Receiver for the FFT core's output stream (push/stall protocol, 16-bit real/imag).
- FFT results leave the core in bit-reversed index order. This block buffers each 16-sample frame in a ping-pong memory and re-emits it in natural order over the same push/stall protocol.
- Sits between the FFT top and any downstream consumer.
- Two banks, so one frame can be written while the previous one is read.

---
 rtl/fft_bitrev_reorder.sv | 105 ++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes FFT output in bit-reversed order and re-emits it in natural order.
// Optional FFT_REORDER_DROP_CNT_EN adds an 8-bit saturating count of pushes dropped while stalled.
module fft_bitrev_reorder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LOG2N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_push,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             in_stall,
    output logic             out_push_F,
    output logic [WIDTH-1:0] out_real_F,
    output logic [WIDTH-1:0] out_imag_F,
    input  logic             out_stall
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int unsigned N = 1 << LOG2N;

    typedef enum logic {StIdle, StStream} state_e;

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   wcnt_q, rcnt_q;
    logic               wbank_q, rbank_q;
    logic [1:0]         full_q, full_d;
    logic               wr_en, wr_last, rd_en, rd_last;
    logic [2*WIDTH-1:0] rd_word;
    logic [2*WIDTH-1:0] mem [0:2*N-1];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    assign in_stall = full_q[wbank_q];
    assign wr_en    = in_push && !full_q[wbank_q];
    assign wr_last  = wr_en && (&wcnt_q);
    assign rd_word  = mem[{rbank_q, rcnt_q}];

    // IDLE emits on the same cycle it sees a full bank, so the first sample
    // appears two cycles after the last push of a frame.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (full_q[rbank_q]) begin
                    state_d = StStream;
                    rd_en   = !out_stall;
                end
            end
            StStream: rd_en = !out_stall;
            default: ;
        endcase
        rd_last = rd_en && (&rcnt_q);
        if (rd_last) state_d = full_q[~rbank_q] ? StStream : StIdle;

        full_d = full_q;
        if (wr_last) full_d[wbank_q] = 1'b1;
        if (rd_last) full_d[rbank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank_q, bitrev(wcnt_q)}] <= {in_real, in_imag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            full_q     <= 2'b00;
            out_push_F <= 1'b0;
            out_real_F <= '0;
            out_imag_F <= '0;
`ifdef FFT_REORDER_DROP_CNT_EN
            drop_cnt   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            out_push_F <= rd_en;
            if (wr_en)   wcnt_q  <= wcnt_q + 1'b1;
            if (wr_last) wbank_q <= ~wbank_q;
            if (rd_en)   rcnt_q  <= rcnt_q + 1'b1;
            if (rd_last) rbank_q <= ~rbank_q;
            if (rd_en) begin
                out_real_F <= rd_word[2*WIDTH-1:WIDTH];
                out_imag_F <= rd_word[WIDTH-1:0];
            end
`ifdef FFT_REORDER_DROP_CNT_EN
            if (in_push && in_stall && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
`endif
        end
    end

endmodule
